// File: rtl/env_adsr_amp_if.sv
// Purpose: bundles the envelope controls, the sample in and the scaled sample/status out.
// Latency: none (wiring only); the attached block registers every output.
// Backpressure: none; one sample moves per clock in each direction.
interface env_adsr_amp_if #(
    parameter int nbit_wav = 14,
    parameter int nbit_env = 8
);
    logic                gate_in;
    logic [nbit_wav-1:0] wav_in;
    logic [nbit_env-1:0] att_rate_in;
    logic [nbit_env-1:0] dec_rate_in;
    logic [nbit_env-1:0] sus_lvl_in;
    logic [nbit_env-1:0] rel_rate_in;
    logic [nbit_wav-1:0] aout;
    logic [nbit_env-1:0] env_out;
    logic [2:0]          state_out;
    logic                busy_out;

    // Producer side: note gate, generator sample and envelope settings.
    modport master (
        output gate_in, wav_in, att_rate_in, dec_rate_in, sus_lvl_in, rel_rate_in,
        input  aout, env_out, state_out, busy_out
    );

    // Envelope block side.
    modport slave (
        input  gate_in, wav_in, att_rate_in, dec_rate_in, sus_lvl_in, rel_rate_in,
        output aout, env_out, state_out, busy_out
    );
endinterface

// File: rtl/env_adsr_amp.sv
// Purpose: ADSR amplitude envelope; scales the generator sample by the current level.
// Latency: state/level move on the edge sampling a gate event or tick; aout is 1 clock after wav_in/env_out.
// Backpressure: none; free-running, one sample accepted and produced every clock.
module env_adsr_amp #(
    parameter int nbit_wav = 14,
    parameter int nbit_env = 8,
    parameter int nbit_pre = 10
) (
    input  logic            clk,
    input  logic            rstn,
    env_adsr_amp_if.slave   io
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam int PW = nbit_wav + nbit_env + 1;
    localparam logic [nbit_env-1:0] LVL_MAX  = {nbit_env{1'b1}};
    localparam logic [nbit_env-1:0] LVL_ZERO = {nbit_env{1'b0}};

    logic [nbit_pre-1:0] pre_q, pre_d;
    logic                tick;
    logic                gate_q;
    logic                rise, fall;
    logic [2:0]          state_q, state_d;
    logic [nbit_env-1:0] lvl_q, lvl_d;
    logic                busy_q, busy_d;
    logic [nbit_wav-1:0] aout_q, aout_d;

    // One extra bit so sums never wrap before saturation.
    logic [nbit_env:0]   att_sum;
    logic [nbit_env:0]   dec_floor;

    logic signed [PW-1:0] wav_ext;
    logic signed [PW-1:0] lvl_ext;
    logic signed [PW-1:0] prod;
    logic                 unused_prod_bits;

    // Prescaler: free-running counter, tick on all-ones.
    always_comb begin
        pre_d = pre_q + {{(nbit_pre-1){1'b0}}, 1'b1};
    end

    assign tick = &pre_q;
    assign rise = io.gate_in & ~gate_q;
    assign fall = ~io.gate_in;

    assign att_sum   = {1'b0, lvl_q} + {1'b0, io.att_rate_in};
    assign dec_floor = {1'b0, io.dec_rate_in} + {1'b0, io.sus_lvl_in};

    // Envelope FSM: gate events first, otherwise per-state level stepping on tick.
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        if (rise) begin
            // Retrigger keeps the current level so attack resumes without a click.
            state_d = ST_ATTACK;
        end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_ATTACK: begin
                    if (tick) begin
                        if (io.att_rate_in == LVL_ZERO || att_sum >= {1'b0, LVL_MAX}) begin
                            lvl_d   = LVL_MAX;
                            state_d = ST_DECAY;
                        end else begin
                            lvl_d = att_sum[nbit_env-1:0];
                        end
                    end
                end
                ST_DECAY: begin
                    if (tick) begin
                        // level - dec <= sus (or level already below sus) clamps to sus.
                        if (io.dec_rate_in == LVL_ZERO || {1'b0, lvl_q} <= dec_floor) begin
                            lvl_d   = io.sus_lvl_in;
                            state_d = ST_SUSTAIN;
                        end else begin
                            lvl_d = lvl_q - io.dec_rate_in;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    // Follows sus_lvl_in every clock so live edits are heard at once.
                    lvl_d = io.sus_lvl_in;
                end
                ST_RELEASE: begin
                    if (tick) begin
                        if (io.rel_rate_in == LVL_ZERO || lvl_q <= io.rel_rate_in) begin
                            lvl_d   = LVL_ZERO;
                            state_d = ST_IDLE;
                        end else begin
                            lvl_d = lvl_q - io.rel_rate_in;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    lvl_d   = LVL_ZERO;
                end
            endcase
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    // Scaling: signed sample times unsigned level, keep the top nbit_wav bits (floor shift).
    assign wav_ext = {{(nbit_env+1){io.wav_in[nbit_wav-1]}}, io.wav_in};
    assign lvl_ext = {{nbit_wav{1'b0}}, 1'b0, lvl_q};
    assign prod    = wav_ext * lvl_ext;
    assign aout_d  = prod[nbit_wav+nbit_env-1:nbit_env];
    assign unused_prod_bits = ^{prod[PW-1], prod[nbit_env-1:0]};

    // State, level, prescaler, gate history and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_q   <= '0;
            gate_q  <= 1'b0;
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            busy_q  <= 1'b0;
            aout_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            gate_q  <= io.gate_in;
            state_q <= state_d;
            lvl_q   <= lvl_d;
            busy_q  <= busy_d;
            aout_q  <= aout_d;
        end
    end

    assign io.aout      = aout_q;
    assign io.env_out   = lvl_q;
    assign io.state_out = state_q;
    assign io.busy_out  = busy_q;
endmodule

// File: tb/tb_env_adsr_amp.sv
// Purpose: self-checking bench for env_adsr_amp against a behavioural envelope model.
// Latency: model is cycle-stepped on the same edges as the design.
// Backpressure: none; stimulus is applied every clock.
module tb_env_adsr_amp;
    localparam int NW   = 14;
    localparam int NE   = 8;
    localparam int NP   = 2;
    localparam int LMAX = (1 << NE) - 1;
    localparam int TPER = 1 << NP;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    env_adsr_amp_if #(.nbit_wav(NW), .nbit_env(NE)) bus ();

    env_adsr_amp #(.nbit_wav(NW), .nbit_env(NE), .nbit_pre(NP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input integer got, input integer exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Behavioural model: integer levels, min/max saturation, cycle count for ticks.
    int m_st, m_lvl, m_aout, m_cnt;
    bit m_gate;
    int w, att, dec, sus, rel;
    bit tk, rs, fl;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st = 0; m_lvl = 0; m_aout = 0; m_cnt = 0; m_gate = 0;
        end else begin
            w   = $signed(bus.wav_in);
            att = bus.att_rate_in; dec = bus.dec_rate_in;
            sus = bus.sus_lvl_in;  rel = bus.rel_rate_in;
            tk  = (m_cnt % TPER) == TPER - 1;
            m_cnt++;
            m_aout = (w * m_lvl) >>> NE;
            rs = bus.gate_in && !m_gate;
            fl = !bus.gate_in;
            m_gate = bus.gate_in;
            if (rs) m_st = 1;
            else if (fl && m_st >= 1 && m_st <= 3) m_st = 4;
            else begin
                case (m_st)
                    1: if (tk) begin
                        m_lvl = (att == 0) ? LMAX : ((m_lvl + att > LMAX) ? LMAX : m_lvl + att);
                        if (m_lvl == LMAX) m_st = 2;
                    end
                    2: if (tk) begin
                        m_lvl = (dec == 0) ? sus : ((m_lvl - dec < sus) ? sus : m_lvl - dec);
                        if (m_lvl == sus) m_st = 3;
                    end
                    3: m_lvl = sus;
                    4: if (tk) begin
                        m_lvl = (rel == 0) ? 0 : ((m_lvl - rel < 0) ? 0 : m_lvl - rel);
                        if (m_lvl == 0) m_st = 0;
                    end
                    default: m_lvl = 0;
                endcase
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        chk("env",   bus.env_out,           m_lvl);
        chk("state", bus.state_out,         m_st);
        chk("busy",  bus.busy_out,          (m_st != 0));
        chk("aout",  $signed(bus.aout),     m_aout);
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.state_out != s && n < budget) begin
            cyc();
            n++;
        end
        chk(tag, bus.state_out, s);
    endtask

    task automatic set_rates(input int a, input int d, input int s, input int r);
        bus.att_rate_in = a[NE-1:0];
        bus.dec_rate_in = d[NE-1:0];
        bus.sus_lvl_in  = s[NE-1:0];
        bus.rel_rate_in = r[NE-1:0];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_env"},   bus.env_out,   0);
        chk({tag, "_state"}, bus.state_out, 0);
        chk({tag, "_busy"},  bus.busy_out,  0);
        chk({tag, "_aout"},  bus.aout,      0);
    endtask

    int seq[$];
    int exp_ad[8] = '{64, 128, 192, 255, 223, 191, 159, 128};
    int exp_rel[2] = '{64, 0};

    task automatic collect_until_state(input int s, input int budget);
        int prev, n;
        seq.delete();
        prev = bus.env_out;
        n = 0;
        while (bus.state_out != s && n < budget) begin
            cyc();
            if (bus.env_out != prev) begin
                seq.push_back(bus.env_out);
                prev = bus.env_out;
            end
            n++;
        end
    endtask

    initial begin
        int n, lv;
        rstn = 1'b0;
        bus.gate_in = 1'b0;
        bus.wav_in  = '0;
        set_rates(64, 32, 128, 64);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        bus.wav_in = 14'd8191;
        repeat (5) cyc();

        // Attack then decay.
        bus.gate_in = 1'b1;
        cyc();
        chk("s1_attack", bus.state_out, 1);
        collect_until_state(3, 80);
        chk("s1_len", seq.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("s1_lvl%0d", i), (i < seq.size()) ? seq[i] : -1, exp_ad[i]);

        // Scaling and live sustain tracking.
        cyc();
        chk("s3_pos", $signed(bus.aout), 4095);
        bus.wav_in = 14'h2000;
        cyc();
        cyc();
        chk("s3_neg", $signed(bus.aout), -4096);
        bus.sus_lvl_in = 8'd100;
        cyc();
        chk("s2_sus_live", bus.env_out, 100);
        bus.sus_lvl_in = 8'd128;
        bus.wav_in = 14'd8191;
        cyc();
        cyc();

        // Release.
        bus.gate_in = 1'b0;
        cyc();
        chk("s2_release", bus.state_out, 4);
        collect_until_state(0, 40);
        chk("s2_len", seq.size(), 2);
        for (int i = 0; i < 2; i++)
            chk($sformatf("s2_lvl%0d", i), (i < seq.size()) ? seq[i] : -1, exp_rel[i]);
        chk("s2_busy", bus.busy_out, 0);
        cyc();
        chk("s3_idle_aout", $signed(bus.aout), 0);

        // Zero rates.
        set_rates(0, 0, 128, 0);
        bus.wav_in = 14'h3fff;
        bus.gate_in = 1'b1;
        cyc();
        wait_state(2, 10, "s5_decay");
        chk("s5_max", bus.env_out, 255);
        cyc();
        chk("s3_m1", $signed(bus.aout), -1);
        wait_state(3, 10, "s5_sustain");
        chk("s5_sus", bus.env_out, 128);
        bus.gate_in = 1'b0;
        cyc();
        chk("s5_rel", bus.state_out, 4);
        wait_state(0, 6, "s5_idle");
        chk("s5_zero", bus.env_out, 0);

        // Retrigger from release.
        set_rates(64, 32, 128, 64);
        bus.wav_in = 14'd8191;
        bus.gate_in = 1'b1;
        cyc();
        wait_state(2, 40, "s4_decay");
        n = 0;
        while (bus.env_out != 191 && n < 20) begin cyc(); n++; end
        chk("s4_191", bus.env_out, 191);
        bus.gate_in = 1'b0;
        n = 0;
        cyc();
        while (bus.env_out == 191 && n < 10) begin cyc(); n++; end
        chk("s4_rel_lvl", bus.env_out, 127);
        chk("s4_rel_st", bus.state_out, 4);
        bus.gate_in = 1'b1;
        cyc();
        chk("s4_att_st", bus.state_out, 1);
        chk("s4_att_lvl", bus.env_out, 127);
        n = 0;
        while (bus.env_out == 127 && n < 10) begin cyc(); n++; end
        chk("s4_step", bus.env_out, 191);

        // Asynchronous reset mid-attack, restart with gate held high.
        cyc();
        rstn = 1'b0;
        #1;
        chk_reset_outputs("s6_rst");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        chk("s6_restart", bus.state_out, 1);

        // Fall coincident with tick in ATTACK.
        n = 0;
        while (!((m_cnt % TPER) == TPER - 1 && bus.env_out > 0 && bus.state_out == 1) && n < 20) begin
            cyc(); n++;
        end
        chk("s6_setup", bus.state_out, 1);
        lv = bus.env_out;
        bus.gate_in = 1'b0;
        cyc();
        chk("s6_fall_st", bus.state_out, 4);
        chk("s6_fall_lvl", bus.env_out, lv);
        wait_state(0, 20, "s6_idle");

        // Randomized run against the model.
        set_rates(40, 20, 90, 30);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.gate_in = ~bus.gate_in;
            bus.wav_in = 14'($urandom_range(0, 16383));
            if (i % 300 == 0)
                set_rates(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 120),
                          ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 120),
                          $urandom_range(0, 255),
                          ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 120));
            if ($urandom_range(0, 99) == 0) bus.sus_lvl_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 999) == 0) begin
                rstn = 1'b0;
                #1;
                chk_reset_outputs("rnd_rst");
                @(negedge clk);
                rstn = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
